// File: rtl/jstk2_pkg.sv
// Shared types and constants for the JSTK2 poll scheduler.
package jstk2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_GAP
    } state_t;

    localparam logic [7:0] CMD_GET_POS = 8'hC0;
    localparam logic [7:0] CMD_SET_LED = 8'h84;

    // Response byte positions used by the position decode.
    localparam int unsigned BYTE_X_LO = 0;
    localparam int unsigned BYTE_X_HI = 1;
    localparam int unsigned BYTE_Y_LO = 2;
    localparam int unsigned BYTE_Y_HI = 3;
    localparam int unsigned BYTE_BTN  = 4;

    // Counter width for a threshold, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Free-running tick counter: pulses tick on its last count while enabled, then wraps.
module wait_counter
    import jstk2_pkg::*;
#(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign tick = en && (count == LAST);

    // Count while enabled, wrap on the last value, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jstk2_poll_scheduler.sv
// Arbitrates periodic position polls against host commands for the JSTK2 SPI driver,
// captures the driver response and enforces inter-transaction gap and timeout.
module jstk2_poll_scheduler
    import jstk2_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = 8,
    parameter int unsigned           TOTAL_DATA_BYTE = 7,
    parameter int unsigned           POLL_PERIOD     = 5000000,
    parameter logic [DATA_WIDTH-1:0] POLL_CMD        = CMD_GET_POS,
    parameter int unsigned           MIN_GAP         = 2500,
    parameter int unsigned           TIMEOUT_CYCLES  = 200000
) (
    input  logic                                  i_clk,
    input  logic                                  i_n_reset,
    input  logic                                  i_enable,
    input  logic                                  i_host_req,
    input  logic [DATA_WIDTH-1:0]                 i_host_cmd,
    input  logic [4*DATA_WIDTH-1:0]               i_host_param,
    output logic                                  o_host_ack,
    output logic                                  o_host_done,
    output logic [TOTAL_DATA_BYTE*DATA_WIDTH-1:0] o_host_rx_data,
    output logic                                  o_fetch,
    output logic [DATA_WIDTH-1:0]                 o_cmd,
    output logic                                  o_cmd_valid,
    output logic [4*DATA_WIDTH-1:0]               o_param,
    input  logic                                  i_drv_done,
    input  logic [TOTAL_DATA_BYTE*DATA_WIDTH-1:0] i_drv_rx_data,
    output logic [9:0]                            o_x,
    output logic [9:0]                            o_y,
    output logic [7:0]                            o_btn,
    output logic                                  o_sample_valid,
    output logic [15:0]                           o_sample_count,
    output logic                                  o_timeout,
    output logic                                  o_err,
    input  logic                                  i_err_clr
);

    state_t state, state_next;

    logic poll_tick, gap_tick, to_tick;
    logic poll_pend, host_pend, cur_host;
    logic in_busy, in_gap;
    logic grant_host, grant_poll, done_busy, timeout_hit;
    logic [DATA_WIDTH-1:0]   host_cmd_q;
    logic [4*DATA_WIDTH-1:0] host_param_q;

    assign in_busy     = (state == ST_BUSY);
    assign in_gap      = (state == ST_GAP);
    assign grant_host  = (state == ST_IDLE) && host_pend;
    // Gating with i_enable makes a disable drop a pending poll in the same cycle.
    assign grant_poll  = (state == ST_IDLE) && !host_pend && poll_pend && i_enable;
    assign done_busy   = in_busy && i_drv_done;
    assign timeout_hit = to_tick && !i_drv_done;

    wait_counter #(.LIMIT(POLL_PERIOD)) u_poll_timer (
        .clk   (i_clk),
        .rst_n (i_n_reset),
        .en    (i_enable),
        .clr   (!i_enable),
        .tick  (poll_tick)
    );

    wait_counter #(.LIMIT(MIN_GAP)) u_gap_timer (
        .clk   (i_clk),
        .rst_n (i_n_reset),
        .en    (in_gap),
        .clr   (!in_gap),
        .tick  (gap_tick)
    );

    wait_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk   (i_clk),
        .rst_n (i_n_reset),
        .en    (in_busy),
        .clr   (!in_busy),
        .tick  (to_tick)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (grant_host || grant_poll) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_BUSY;
            ST_BUSY:  if (i_drv_done || to_tick) state_next = ST_GAP;
            ST_GAP:   if (gap_tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded driver strobes.
    always_comb begin
        o_fetch     = (state == ST_ISSUE);
        o_cmd_valid = (state == ST_ISSUE) || (state == ST_BUSY);
    end

    // Host latch, poll pending flag and command selection for the driver.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            host_pend    <= 1'b0;
            host_cmd_q   <= '0;
            host_param_q <= '0;
            o_host_ack   <= 1'b0;
            poll_pend    <= 1'b0;
            o_cmd        <= '0;
            o_param      <= '0;
            cur_host     <= 1'b0;
        end else begin
            o_host_ack <= 1'b0;
            if (!host_pend && i_host_req) begin
                host_cmd_q   <= i_host_cmd;
                host_param_q <= i_host_param;
                host_pend    <= 1'b1;
                o_host_ack   <= 1'b1;
            end else if (grant_host) begin
                host_pend <= 1'b0;
            end

            if (!i_enable) begin
                poll_pend <= 1'b0;
            end else if (poll_tick) begin
                poll_pend <= 1'b1;
            end else if (grant_poll) begin
                poll_pend <= 1'b0;
            end

            if (grant_host) begin
                o_cmd    <= host_cmd_q;
                o_param  <= host_param_q;
                cur_host <= 1'b1;
            end else if (grant_poll) begin
                o_cmd    <= POLL_CMD;
                o_param  <= '0;
                cur_host <= 1'b0;
            end
        end
    end

    // Response capture, completion pulses and sticky error flag.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            o_host_rx_data <= '0;
            o_host_done    <= 1'b0;
            o_x            <= '0;
            o_y            <= '0;
            o_btn          <= '0;
            o_sample_valid <= 1'b0;
            o_sample_count <= '0;
            o_timeout      <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            o_sample_valid <= 1'b0;
            o_host_done    <= 1'b0;
            o_timeout      <= 1'b0;
            if (done_busy) begin
                if (cur_host) begin
                    o_host_rx_data <= i_drv_rx_data;
                    o_host_done    <= 1'b1;
                end else begin
                    o_x <= {i_drv_rx_data[BYTE_X_HI*DATA_WIDTH +: 2],
                            i_drv_rx_data[BYTE_X_LO*DATA_WIDTH +: 8]};
                    o_y <= {i_drv_rx_data[BYTE_Y_HI*DATA_WIDTH +: 2],
                            i_drv_rx_data[BYTE_Y_LO*DATA_WIDTH +: 8]};
                    o_btn          <= i_drv_rx_data[BYTE_BTN*DATA_WIDTH +: 8];
                    o_sample_valid <= 1'b1;
                    o_sample_count <= o_sample_count + 16'd1;
                end
            end else if (timeout_hit) begin
                o_timeout   <= 1'b1;
                o_host_done <= cur_host;
            end

            if (timeout_hit) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jstk2_poll_scheduler.sv
// Directed bench for jstk2_poll_scheduler with a fixed-latency driver model.
module tb_jstk2_poll_scheduler;
    import jstk2_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NB = 7;
    localparam int unsigned PP = 100;
    localparam int unsigned MG = 4;
    localparam int unsigned TO = 50;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_enable = 1'b0;
    logic           i_host_req = 1'b0;
    logic [DW-1:0]  i_host_cmd = '0;
    logic [4*DW-1:0] i_host_param = '0;
    logic           o_host_ack, o_host_done;
    logic [NB*DW-1:0] o_host_rx_data;
    logic           o_fetch, o_cmd_valid;
    logic [DW-1:0]  o_cmd;
    logic [4*DW-1:0] o_param;
    logic           i_drv_done = 1'b0;
    logic [NB*DW-1:0] drv_data = '0;
    logic [9:0]     o_x, o_y;
    logic [7:0]     o_btn;
    logic           o_sample_valid;
    logic [15:0]    o_sample_count;
    logic           o_timeout, o_err;
    logic           i_err_clr = 1'b0;
    logic           drv_mute = 1'b0;

    jstk2_poll_scheduler #(
        .POLL_PERIOD    (PP),
        .MIN_GAP        (MG),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_n_reset      (rst_n),
        .i_enable       (i_enable),
        .i_host_req     (i_host_req),
        .i_host_cmd     (i_host_cmd),
        .i_host_param   (i_host_param),
        .o_host_ack     (o_host_ack),
        .o_host_done    (o_host_done),
        .o_host_rx_data (o_host_rx_data),
        .o_fetch        (o_fetch),
        .o_cmd          (o_cmd),
        .o_cmd_valid    (o_cmd_valid),
        .o_param        (o_param),
        .i_drv_done     (i_drv_done),
        .i_drv_rx_data  (drv_data),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_btn          (o_btn),
        .o_sample_valid (o_sample_valid),
        .o_sample_count (o_sample_count),
        .o_timeout      (o_timeout),
        .o_err          (o_err),
        .i_err_clr      (i_err_clr)
    );

    always #5 clk = ~clk;

    // Cycles since reset release, counted on rising edges.
    int cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // Event recorder, sampled on the falling edge.
    int          n_fetch, n_ack, n_hdone, n_sv, n_to;
    int          fetch_cyc [8];
    logic [7:0]  fetch_cmd [8];
    logic [31:0] fetch_par [8];
    int          ack_cyc [8];
    int          last_hdone_cyc, last_sv_cyc, last_to_cyc;
    logic        to_cv;
    always @(negedge clk) begin
        if (!rst_n) begin
            n_fetch = 0; n_ack = 0; n_hdone = 0; n_sv = 0; n_to = 0;
        end else begin
            if (o_fetch && n_fetch < 8) begin
                fetch_cyc[n_fetch] = cyc;
                fetch_cmd[n_fetch] = o_cmd;
                fetch_par[n_fetch] = o_param;
                n_fetch = n_fetch + 1;
            end
            if (o_host_ack && n_ack < 8) begin
                ack_cyc[n_ack] = cyc;
                n_ack = n_ack + 1;
            end
            if (o_host_done)    begin n_hdone = n_hdone + 1; last_hdone_cyc = cyc; end
            if (o_sample_valid) begin n_sv = n_sv + 1; last_sv_cyc = cyc; end
            if (o_timeout)      begin n_to = n_to + 1; last_to_cyc = cyc; to_cv = o_cmd_valid; end
        end
    end

    // Driver model: done 20 cycles after fetch unless muted.
    int drv_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            drv_cnt = 0;
            i_drv_done = 1'b0;
        end else begin
            i_drv_done = 1'b0;
            if (drv_cnt > 0) begin
                drv_cnt = drv_cnt - 1;
                if (drv_cnt == 0 && !drv_mute) i_drv_done = 1'b1;
            end
            if (o_fetch) drv_cnt = 20;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_until(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard = guard + 1;
        end while (cyc < n && guard < 5000);
        #1;
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (o_host_ack) break;
        end
        chk(tag, o_host_ack, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_enable = 1'b0;
        i_host_req = 1'b0;
        i_err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_fetch", o_fetch, 1'b0);
        chk("rst_cmd_valid", o_cmd_valid, 1'b0);
        chk("rst_cmd", o_cmd, 8'h00);
        chk("rst_count", o_sample_count, 16'h0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_host_rx", o_host_rx_data, 56'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [55:0] POS_DATA = 56'h0000_0501_FF02_03;
    localparam logic [55:0] H_DATA   = 56'h17_1615_1413_1211;
    localparam logic [55:0] D1_DATA  = 56'h21_2223_2425_2627;
    localparam logic [55:0] D2_DATA  = 56'h31_3233_3435_3637;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Poll path with decode.
        do_reset();
        i_enable = 1'b1;
        drv_data = POS_DATA;
        run_until(130);
        chk("poll_n_fetch", n_fetch, 1);
        chk("poll_fetch_cyc", fetch_cyc[0], 101);
        chk("poll_cmd", fetch_cmd[0], CMD_GET_POS);
        chk("poll_param", fetch_par[0], 32'h0);
        chk("poll_sv_cyc", last_sv_cyc, 122);
        chk("poll_n_sv", n_sv, 1);
        chk("poll_x", o_x, 10'h203);
        chk("poll_y", o_y, 10'h1FF);
        chk("poll_btn", o_btn, 8'h05);
        chk("poll_count", o_sample_count, 16'd1);

        // Host and poll pending together: host first, poll after the gap.
        run_until(199);
        drv_data = H_DATA;
        i_host_cmd = CMD_SET_LED;
        i_host_param = 32'h0030_2010;
        i_host_req = 1'b1;
        wait_ack("prio_ack");
        i_host_req = 1'b0;
        run_until(260);
        chk("prio_ack_cyc", ack_cyc[0], 200);
        chk("prio_n_ack", n_ack, 1);
        chk("prio_host_cyc", fetch_cyc[1], 201);
        chk("prio_host_cmd", fetch_cmd[1], CMD_SET_LED);
        chk("prio_host_par", fetch_par[1], 32'h0030_2010);
        chk("prio_n_hdone", n_hdone, 1);
        chk("prio_hdone_cyc", last_hdone_cyc, 222);
        chk("prio_host_rx", o_host_rx_data, H_DATA);
        chk("prio_poll_cmd", fetch_cmd[2], CMD_GET_POS);
        chk("prio_poll_gap", fetch_cyc[2] - last_hdone_cyc, MG + 1);
        chk("prio_count", o_sample_count, 16'd2);

        // Second request held while the first is pending.
        i_enable = 1'b0;
        drv_data = D1_DATA;
        run_until(265);
        i_host_cmd = CMD_SET_LED;
        i_host_param = 32'hAABB_CCDD;
        i_host_req = 1'b1;
        wait_ack("hs_ack_a");
        i_host_cmd = 8'h85;
        i_host_param = 32'h1122_3344;
        wait_ack("hs_ack_b");
        i_host_req = 1'b0;
        run_until(290);
        chk("hs_rx_a", o_host_rx_data, D1_DATA);
        drv_data = D2_DATA;
        run_until(330);
        chk("hs_n_ack", n_ack, 3);
        chk("hs_ack_a_cyc", ack_cyc[1], 266);
        chk("hs_fetch_a_cyc", fetch_cyc[3], 267);
        chk("hs_ack_after_issue", ack_cyc[2] - fetch_cyc[3], 1);
        chk("hs_cmd_a", fetch_cmd[3], CMD_SET_LED);
        chk("hs_par_a", fetch_par[3], 32'hAABB_CCDD);
        chk("hs_cmd_b", fetch_cmd[4], 8'h85);
        chk("hs_par_b", fetch_par[4], 32'h1122_3344);
        chk("hs_fetch_b_cyc", fetch_cyc[4], 293);
        chk("hs_rx_b", o_host_rx_data, D2_DATA);

        // Host transaction with no driver response.
        drv_mute = 1'b1;
        i_host_cmd = CMD_SET_LED;
        i_host_param = 32'h0;
        i_host_req = 1'b1;
        wait_ack("hto_ack");
        i_host_req = 1'b0;
        run_until(400);
        chk("hto_fetch_cyc", fetch_cyc[5], 332);
        chk("hto_to_cyc", last_to_cyc, 383);
        chk("hto_n_to", n_to, 1);
        chk("hto_hdone_cyc", last_hdone_cyc, 383);
        chk("hto_cmd_valid", to_cv, 1'b0);
        chk("hto_rx_kept", o_host_rx_data, D2_DATA);
        chk("hto_err", o_err, 1'b1);
        i_err_clr = 1'b1;
        run_until(401);
        i_err_clr = 1'b0;
        chk("hto_err_clr", o_err, 1'b0);

        // Poll timeout, clear held across the setting cycle.
        do_reset();
        i_enable = 1'b1;
        drv_data = POS_DATA;
        run_until(140);
        i_err_clr = 1'b1;
        run_until(152);
        chk("pto_to_cyc", last_to_cyc, 152);
        chk("pto_err_set_wins", o_err, 1'b1);
        run_until(153);
        chk("pto_err_cleared", o_err, 1'b0);
        i_err_clr = 1'b0;
        run_until(205);
        chk("pto_n_sv", n_sv, 0);
        chk("pto_count", o_sample_count, 16'd0);
        chk("pto_x", o_x, 10'h0);
        chk("pto_n_fetch", n_fetch, 2);
        chk("pto_next_fetch", fetch_cyc[1], 201);
        chk("pto_n_hdone", n_hdone, 0);

        // Disable with a poll pending.
        do_reset();
        drv_mute = 1'b0;
        i_enable = 1'b1;
        run_until(100);
        i_enable = 1'b0;
        run_until(250);
        chk("dis_no_fetch", n_fetch, 0);
        i_enable = 1'b1;
        run_until(355);
        chk("dis_reen_n_fetch", n_fetch, 1);
        chk("dis_reen_cyc", fetch_cyc[0], 351);

        // Asynchronous reset mid-transaction.
        do_reset();
        i_enable = 1'b1;
        run_until(110);
        chk("ar_busy_valid", o_cmd_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cmd_valid", o_cmd_valid, 1'b0);
        chk("ar_fetch", o_fetch, 1'b0);
        chk("ar_cmd", o_cmd, 8'h00);
        chk("ar_param", o_param, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_until(105);
        chk("ar_n_fetch", n_fetch, 1);
        chk("ar_fetch_cyc", fetch_cyc[0], 101);

        // Sample counter wrap.
        do_reset();
        i_enable = 1'b1;
        drv_data = POS_DATA;
        run_until(50);
        force dut.o_sample_count = 16'hFFFF;
        run_until(52);
        release dut.o_sample_count;
        run_until(60);
        chk("wrap_preload", o_sample_count, 16'hFFFF);
        run_until(130);
        chk("wrap_n_sv", n_sv, 1);
        chk("wrap_count", o_sample_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jstk2_poll_scheduler.md
Name: jstk2_poll_scheduler

Overview:
Sequences the JSTK2 SPI driver. It issues periodic position polls and arbitrates them against one-shot host (PS AXI) command requests, such as LED set. It captures the 7-byte driver response, decodes X/Y/buttons for polls, and enforces a minimum inter-transaction gap and a per-transaction timeout. It sits between the AXI register slice and the driver's fetch/cmd/param/done/rx_data interface.

Parameters:
DATA_WIDTH, 8, byte width of cmd/params
TOTAL_DATA_BYTE, 7, response bytes from driver
POLL_PERIOD, 5000000, clk cycles between poll requests (50 ms @ 100 MHz)
POLL_CMD, 8'hC0, command byte used for polls (params all 0)
MIN_GAP, 2500, idle clk cycles enforced after each transaction
TIMEOUT_CYCLES, 200000, max cycles waiting for driver done

Ports:
i_clk  in  1  system clock
i_n_reset  in  1  asynchronous, active-low reset
i_enable  in  1  polling enable; host requests are served regardless
i_host_req  in  1  host command request, held until o_host_ack
i_host_cmd  in  DATA_WIDTH  host command byte
i_host_param  in  4*DATA_WIDTH  params 1..4, param_1 in [7:0]
o_host_ack  out  1  1-cycle pulse: request latched
o_host_done  out  1  1-cycle pulse: host transaction ended (ok or timeout)
o_host_rx_data  out  TOTAL_DATA_BYTE*DATA_WIDTH  response of last host transaction
o_fetch  out  1  1-cycle start pulse to driver
o_cmd  out  DATA_WIDTH  command to driver
o_cmd_valid  out  1  high from ISSUE through BUSY
o_param  out  4*DATA_WIDTH  params to driver
i_drv_done  in  1  driver completion pulse
i_drv_rx_data  in  TOTAL_DATA_BYTE*DATA_WIDTH  driver response; byte0 = [7:0]
o_x  out  10  {byte1[1:0], byte0}
o_y  out  10  {byte3[1:0], byte2}
o_btn  out  8  byte4
o_sample_valid  out  1  1-cycle pulse when o_x/o_y/o_btn update
o_sample_count  out  16  successful polls, wraps at 16'hFFFF->0
o_timeout  out  1  1-cycle pulse on timeout
o_err  out  1  sticky timeout flag
i_err_clr  in  1  clears o_err; a set in the same cycle wins

Behaviour:
- Reset (async assert, sync-released by system): state IDLE; all outputs, pendings and counters are 0.
- Poll timer: counts while i_enable=1. On reaching POLL_PERIOD-1 it wraps to 0 and sets poll_pend. If poll_pend is already set it stays set; no queuing.
- i_enable=0 clears the timer and poll_pend at once. It does not abort an in-flight poll.
- Host latch: host_pend=0 and i_host_req=1 -> latch cmd/params, set host_pend, pulse o_host_ack next cycle. Works in any state.
- While host_pend=1, i_host_req gets no ack.
- FSM IDLE: host_pend has priority over poll_pend. If both are set, host wins and poll_pend is retained. IDLE -> ISSUE registers o_cmd/o_param from the winner and clears that pending.
- FSM ISSUE (1 cycle): o_fetch=1, o_cmd_valid=1, then -> BUSY. Latency from IDLE seeing a pending request to o_fetch is 1 cycle.
- FSM BUSY: o_cmd_valid=1, o_cmd/o_param stable, and the timeout counter increments.
  - On i_drv_done, capture and go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done, pulse o_timeout, set o_err, and go to GAP.
  - done and timeout in the same cycle: done wins.
  - i_drv_done outside BUSY is ignored.
- Capture, poll: o_x/o_y/o_btn update, o_sample_valid pulses, o_sample_count increments.
- Capture, host: o_host_rx_data updates and o_host_done pulses. On host timeout, o_host_done still pulses and o_host_rx_data is unchanged.
- Poll timeout: no sample update, count unchanged.
- FSM GAP: o_cmd_valid=0. Count MIN_GAP cycles, then -> IDLE.
- Counter widths are derived by $clog2 of their thresholds, minimum 1.
- Mid-operation reset: immediate return to IDLE with outputs 0. The driver shares the same reset.

Decomposition:
- Shared package jstk2_pkg holds:
  - state encoding (IDLE, ISSUE, BUSY, GAP);
  - command constants CMD_GET_POS = 8'hC0 and CMD_SET_LED = 8'h84;
  - byte-index constants for X/Y/button decode.
- One natural sub-module: the existing wait_counter in tick mode, instantiated three times (poll period, gap, timeout).
  - If its enable/clear semantics do not suit the timeout, use a local cycle_timer instead.

Test Plan:
- Bench parameters: POLL_PERIOD=100, MIN_GAP=4, TIMEOUT_CYCLES=50. The driver model returns done 20 cycles after fetch.
- Poll: i_enable=1, rx bytes 03,02,FF,01,05 -> o_fetch at cycle ~101 with o_cmd=C0; o_x=0x203, o_y=0x1FF, o_btn=0x05, o_sample_valid 1 pulse, count=1.
- Priority: host req (cmd 84, params 10,20,30,00) in the same cycle poll_pend sets -> host fetched first. The poll is fetched exactly 4 gap cycles after host done. o_host_ack is 1 pulse and o_host_done is 1 pulse.
- Handshake: a second i_host_req held while host_pend=1 -> no ack until the first is issued. Then ack on the next cycle, and served in order.
- Timeout: driver never sends done -> o_timeout at 50 BUSY cycles and o_err=1. Sample unchanged, FSM back to IDLE after gap. i_err_clr -> o_err=0.
- Disable/reset: i_enable dropped with poll_pend=1 -> no fetch. Async reset asserted during BUSY -> all outputs 0 immediately, and the next poll occurs 100 cycles after release.
- Wrap: preload/force 65535 successful polls -> o_sample_count wraps to 0.
